// File: rtl/muldiv_pkg.sv
// Shared ALU op codes, sequencer state encoding and step-mode select for muldiv_seq.
package muldiv_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;
    localparam logic [3:0] ALU_DIV = 4'b0111;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic logic op_accepted(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] fix_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opnd_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        sum    = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, fix_i} : '0);
        rem_sh = {acc_i, opnd_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, fix_i};
        acc_o  = sum[WIDTH:1];
        opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
        if (mode_i == MODE_DIV) begin
            // rem < divisor keeps rem_sh < 2*divisor, so bit WIDTH of trial is a true sign
            if (!trial[WIDTH]) begin
                acc_o  = trial[WIDTH-1:0];
                opnd_o = {opnd_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = rem_sh[WIDTH-1:0];
                opnd_o = {opnd_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer, one bit per cycle, stalling the core while busy.
// Optional MULDIV_EARLY_EXIT_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             busy,
    output logic             done,
    output logic             Stall,
    output logic             DivZero
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, opnd_q, fix_q;
    logic [WIDTH-1:0]   res_q, hi_q;
    logic               busy_q, done_q, dz_q;

    logic [WIDTH-1:0]   acc_n, opnd_n, res_n, hi_n;
    logic               last, mul_fin, fin;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (state_q == DIV_RUN ? MODE_DIV : MODE_MUL),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .fix_i  (fix_q),
        .acc_o  (acc_n),
        .opnd_o (opnd_n)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] sh;
    // sh = shifts still owed; the low sh bits of opnd_n are the unconsumed multiplier
    assign sh      = CNT_W'(WIDTH - 1) - cnt_q;
    assign mul_fin = (opnd_n & ~({WIDTH{1'b1}} << sh)) == '0;
    assign {hi_n, res_n} = {acc_n, opnd_n} >> sh;
`else
    assign mul_fin = 1'b0;
    assign res_n   = opnd_n;
    assign hi_n    = acc_n;
`endif

    assign fin = last | ((state_q == MUL_RUN) & mul_fin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            fix_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && op_accepted(ALUControl)) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                        dz_q  <= 1'b0;
                        if (ALUControl == ALU_MUL) begin
                            opnd_q  <= SrcB;
                            fix_q   <= SrcA;
                            busy_q  <= 1'b1;
                            state_q <= MUL_RUN;
                        end else if (SrcB == '0) begin
                            res_q   <= '1;
                            hi_q    <= SrcA;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            opnd_q  <= SrcA;
                            fix_q   <= SrcB;
                            busy_q  <= 1'b1;
                            state_q <= DIV_RUN;
                        end
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    acc_q  <= acc_n;
                    opnd_q <= opnd_n;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (fin) begin
                        res_q   <= res_n;
                        hi_q    <= hi_n;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Result   = res_q;
    assign ResultHi = hi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign DivZero  = dz_q;
    assign Stall    = busy_q | ((state_q == IDLE) & start & op_accepted(ALUControl));

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the multicycle core's ALU path. It handles the long-latency ALUControl codes (MUL 4'b0100, DIV 4'b0111) with a shift-add multiplier and a restoring divider, one bit per cycle. While the operation runs it asserts Stall so the main FSM holds in its execute state. The datapath muxes Result into ALUResult when done is seen.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start  in  1  request from main FSM; sampled only in IDLE
ALUControl  in  4  operation code; only 4'b0100 (MUL) and 4'b0111 (DIV) are accepted
SrcA  in  WIDTH  multiplicand / dividend (unsigned)
SrcB  in  WIDTH  multiplier / divisor (unsigned)
Result  out  WIDTH  low product word or quotient
ResultHi  out  WIDTH  high product word or remainder
busy  out  1  high in MUL_RUN or DIV_RUN
done  out  1  one-cycle pulse in DONE state
Stall  out  1  combinational: busy | (state==IDLE & start & op accepted)
DivZero  out  1  set with done when DIV has SrcB==0; held until next accepted start

Behaviour:
- Reset is asynchronous. The block goes to state IDLE with count=0. Result, ResultHi, busy, done and DivZero are all 0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE with start=1 and ALUControl=MUL:
  - Latch SrcA and SrcB; clear the accumulator; clear DivZero; count=0.
  - Next state is MUL_RUN.
- IDLE with start=1 and ALUControl=DIV, SrcB!=0:
  - Latch the operands; clear the remainder; count=0.
  - Next state is DIV_RUN.
- IDLE with start=1 and ALUControl=DIV, SrcB==0:
  - Next state is DONE.
  - Result=all-ones, ResultHi=SrcA, DivZero=1.
- IDLE with start=1 and any other ALUControl: ignored. Stall=0 and the state stays IDLE.
- MUL_RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator (the carry is kept).
  - Shift the {acc, multiplier} pair right by 1; count++.
  - After count reaches WIDTH-1, go to DONE. Result = low word, ResultHi = high word.
- DIV_RUN, each cycle:
  - Shift {rem, quotient} left by 1 and compute trial = rem - divisor at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quotient LSB = 1.
  - After WIDTH iterations, go to DONE. Result = quotient, ResultHi = remainder.
- DONE lasts one cycle with done=1, busy=0 and Stall=0, then returns to IDLE.
- Latency: start accepted at edge k → done high during cycle k+WIDTH+1; for DIV by zero, during cycle k+1.
- Result, ResultHi and DivZero hold their values in IDLE until the next accepted start.
- Start while busy or in DONE is ignored; there is no queueing.
- An operand change during the run has no effect, because the operands were latched at start.
- Reset mid-operation aborts immediately. No done pulse is produced and the outputs return to 0.
- All arithmetic is unsigned and the product is exact at 2*WIDTH bits.

Optional Feature:
MULDIV_EARLY_EXIT_EN:
- Defined: in MUL_RUN, when the remaining (shifted) multiplier bits are all zero, finish the remaining shifts in a single step and go to DONE the next cycle. Results are identical to the full run; only latency shrinks. Example: SrcB=1 → done at k+2.
- Undefined: fixed latency of WIDTH+1 cycles for MUL.
- DIV timing is unchanged in both cases.

Decomposition:
- Package muldiv_pkg holds:
  - the ALU op localparams (ALU_ADD 4'b0000, ALU_SUB 4'b0001, ALU_AND 4'b0010, ALU_ORR 4'b0011, ALU_MUL 4'b0100, ALU_MOV 4'b0101, ALU_DIV 4'b0111);
  - the state encoding (IDLE=2'd0, MUL_RUN=2'd1, DIV_RUN=2'd2, DONE=2'd3).
- One sub-module, muldiv_step: purely combinational single-iteration core. Given mode, acc/rem, the shifting operand and the fixed operand, it returns the next acc/rem and operand. The FSM, counter and registers stay in muldiv_seq.

Test Plan:
- reset asserted mid-cycle with no clock edge → all outputs 0 immediately; state IDLE.
- MUL SrcA=6, SrcB=7, start 1 cycle → Stall high the same cycle; done at k+33; Result=42, ResultHi=0, DivZero=0.
- MUL SrcA=32'hFFFFFFFF, SrcB=2 → Result=32'hFFFFFFFE, ResultHi=1.
- DIV SrcA=100, SrcB=7 → done at k+33, Result=14, ResultHi=2; then DIV SrcB=0, SrcA=5 → done at k+1, Result=32'hFFFFFFFF, ResultHi=5, DivZero=1.
- Start pulsed again at cycle k+5 of a running MUL, and start with ALUControl=4'b0000 in IDLE → both ignored; exactly one done pulse; Stall=0 for the ADD.
- reset pulsed at cycle k+10 of a DIV → no done; outputs 0; a new MUL 3*5 started afterwards → Result=15 (with MULDIV_EARLY_EXIT_EN: done at k+4).
